// File: rtl/ace_snoop_bcast_ctrl.sv
// ACE snoop broadcast controller: fans one upstream AC snoop out to the enabled
// ports, collects their CR responses and returns a single OR-merged response.
module ace_snoop_bcast_ctrl #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 44
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [NUM_PORTS-1:0]   port_en,
    input  logic                   acvalids,
    output logic                   acreadys,
    input  logic [ADDR_W-1:0]      acaddrs,
    input  logic [3:0]             acsnoops,
    input  logic [2:0]             acprots,
    output logic [NUM_PORTS-1:0]   acvalidm,
    input  logic [NUM_PORTS-1:0]   acreadym,
    output logic [ADDR_W-1:0]      acaddrm,
    output logic [3:0]             acsnoopm,
    output logic [2:0]             acprotm,
    input  logic [NUM_PORTS-1:0]   crvalidm,
    output logic [NUM_PORTS-1:0]   crreadym,
    input  logic [5*NUM_PORTS-1:0] crrespm,
    output logic                   crvalids,
    input  logic                   crreadys,
    output logic [4:0]             crresps
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SNOOP = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [NUM_PORTS-1:0]   ac_pend_reg, ac_pend_next;
    logic [NUM_PORTS-1:0]   cr_pend_reg, cr_pend_next;
    logic [4:0]             resp_acc_reg, resp_acc_next;
    logic [ADDR_W-1:0]      addr_reg;
    logic [3:0]             snoop_reg;
    logic [2:0]             prot_reg;

    logic                   ac_accept;
    logic [NUM_PORTS-1:0]   ac_hs;
    logic [NUM_PORTS-1:0]   cr_hs;
    logic [4:0]             cr_slice [NUM_PORTS];
    logic [4:0]             cr_merge;

    assign ac_accept = acvalids & (state_reg == ST_IDLE);
    assign ac_hs     = acvalidm & acreadym;
    assign cr_hs     = crvalidm & crreadym;

    // Only slices that actually hand-shake this cycle contribute to the merge.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_slice
            assign cr_slice[gi] = cr_hs[gi] ? crrespm[5*gi +: 5] : 5'd0;
        end
    endgenerate

    always_comb begin
        cr_merge = 5'd0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cr_merge = cr_merge | cr_slice[i];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg    <= ST_IDLE;
            ac_pend_reg  <= '0;
            cr_pend_reg  <= '0;
            resp_acc_reg <= '0;
            addr_reg     <= '0;
            snoop_reg    <= '0;
            prot_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            ac_pend_reg  <= ac_pend_next;
            cr_pend_reg  <= cr_pend_next;
            resp_acc_reg <= resp_acc_next;
            if (ac_accept) begin
                addr_reg  <= acaddrs;
                snoop_reg <= acsnoops;
                prot_reg  <= acprots;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        ac_pend_next  = ac_pend_reg;
        cr_pend_next  = cr_pend_reg;
        resp_acc_next = resp_acc_reg;
        case (state_reg)
            ST_IDLE: begin
                if (acvalids) begin
                    ac_pend_next  = port_en;
                    cr_pend_next  = port_en;
                    resp_acc_next = 5'd0;
                    state_next    = (port_en != '0) ? ST_SNOOP : ST_RESP;
                end
            end
            ST_SNOOP: begin
                ac_pend_next  = ac_pend_reg & ~ac_hs;
                cr_pend_next  = cr_pend_reg & ~cr_hs;
                resp_acc_next = resp_acc_reg | cr_merge;
                if (cr_pend_next == '0) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (crreadys) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // CR is only accepted from ports whose AC has already completed.
    always_comb begin
        acreadys = (state_reg == ST_IDLE);
        acvalidm = '0;
        crreadym = '0;
        crvalids = 1'b0;
        crresps  = 5'd0;
        if (state_reg == ST_SNOOP) begin
            acvalidm = ac_pend_reg;
            crreadym = cr_pend_reg & ~ac_pend_reg;
        end
        if (state_reg == ST_RESP) begin
            crvalids = 1'b1;
            crresps  = resp_acc_reg;
        end
    end

    assign acaddrm  = addr_reg;
    assign acsnoopm = snoop_reg;
    assign acprotm  = prot_reg;

endmodule

// File: tb/tb_ace_snoop_bcast_ctrl.sv
// Self-checking bench for ace_snoop_bcast_ctrl: directed scenarios plus random
// traffic, compared each cycle against a transaction-level reference model.
module tb_ace_snoop_bcast_ctrl;

    localparam int NP = 4;
    localparam int AW = 44;
    localparam int RW = 5 * NP;

    logic           aclk = 1'b0;
    logic           aresetn;
    logic [NP-1:0]  port_en;
    logic           acvalids;
    logic           acreadys;
    logic [AW-1:0]  acaddrs;
    logic [3:0]     acsnoops;
    logic [2:0]     acprots;
    logic [NP-1:0]  acvalidm;
    logic [NP-1:0]  acreadym;
    logic [AW-1:0]  acaddrm;
    logic [3:0]     acsnoopm;
    logic [2:0]     acprotm;
    logic [NP-1:0]  crvalidm;
    logic [NP-1:0]  crreadym;
    logic [RW-1:0]  crrespm;
    logic           crvalids;
    logic           crreadys;
    logic [4:0]     crresps;

    always #5 aclk = ~aclk;

    ace_snoop_bcast_ctrl #(.NUM_PORTS(NP), .ADDR_W(AW)) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .port_en  (port_en),
        .acvalids (acvalids),
        .acreadys (acreadys),
        .acaddrs  (acaddrs),
        .acsnoops (acsnoops),
        .acprots  (acprots),
        .acvalidm (acvalidm),
        .acreadym (acreadym),
        .acaddrm  (acaddrm),
        .acsnoopm (acsnoopm),
        .acprotm  (acprotm),
        .crvalidm (crvalidm),
        .crreadym (crreadym),
        .crrespm  (crrespm),
        .crvalids (crvalids),
        .crreadys (crreadys),
        .crresps  (crresps)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_snoops = 0;

    task automatic tb_check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transaction-level model: which enabled ports have finished AC / CR,
    // and the OR of every response collected so far.
    bit            m_busy;
    bit            m_resp;
    bit [NP-1:0]   m_en;
    bit [NP-1:0]   m_ac_done;
    bit [NP-1:0]   m_cr_done;
    bit [4:0]      m_acc;
    bit [AW-1:0]   m_addr;
    bit [3:0]      m_snoop;
    bit [2:0]      m_prot;
    logic [NP-1:0] exp_acv;
    logic [NP-1:0] exp_crr;

    task automatic model_reset();
        m_busy = 0; m_resp = 0; m_en = '0; m_ac_done = '0; m_cr_done = '0;
        m_acc = '0; m_addr = '0; m_snoop = '0; m_prot = '0;
    endtask

    task automatic check_outputs();
        exp_acv = '0;
        exp_crr = '0;
        for (int i = 0; i < NP; i++) begin
            if (m_busy && m_en[i] && !m_ac_done[i]) exp_acv[i] = 1'b1;
            if (m_busy && m_en[i] && m_ac_done[i] && !m_cr_done[i]) exp_crr[i] = 1'b1;
        end
        tb_check("acreadys", 64'(acreadys), 64'(!m_busy && !m_resp));
        tb_check("acvalidm", 64'(acvalidm), 64'(exp_acv));
        tb_check("crreadym", 64'(crreadym), 64'(exp_crr));
        tb_check("crvalids", 64'(crvalids), 64'(m_resp));
        tb_check("crresps",  64'(crresps),  m_resp ? 64'(m_acc) : 64'd0);
        tb_check("acaddrm",  64'(acaddrm),  64'(m_addr));
        tb_check("acsnoopm", 64'(acsnoopm), 64'(m_snoop));
        tb_check("acprotm",  64'(acprotm),  64'(m_prot));
    endtask

    task automatic model_step();
        if (!m_busy && !m_resp) begin
            if (acvalids) begin
                m_addr = acaddrs; m_snoop = acsnoops; m_prot = acprots;
                m_en = port_en; m_ac_done = '0; m_cr_done = '0; m_acc = '0;
                if (port_en == '0) m_resp = 1; else m_busy = 1;
                n_snoops++;
                $display("snoop %0d accepted: addr=%0h en=%b", n_snoops, acaddrs, port_en);
            end
        end else if (m_busy) begin
            for (int i = 0; i < NP; i++) begin
                if (exp_acv[i] && acreadym[i]) m_ac_done[i] = 1;
                if (exp_crr[i] && crvalidm[i]) begin
                    m_cr_done[i] = 1;
                    m_acc = m_acc | crrespm[5*i +: 5];
                end
            end
            if ((m_cr_done & m_en) == m_en) begin
                m_busy = 0;
                m_resp = 1;
            end
        end else if (crreadys) begin
            m_resp = 0;
            $display("snoop %0d response returned: resp=%0h", n_snoops, m_acc);
        end
    endtask

    task automatic cycle();
        check_outputs();
        model_step();
        @(negedge aclk);
    endtask

    task automatic rand_inputs();
        acvalids = 1'($urandom_range(0, 1));
        port_en  = ($urandom_range(0, 7) == 0) ? '0 : NP'($urandom);
        acaddrs  = AW'({$urandom, $urandom});
        acsnoops = 4'($urandom);
        acprots  = 3'($urandom);
        acreadym = NP'($urandom);
        crvalidm = NP'($urandom);
        crrespm  = RW'($urandom);
        crreadys = ($urandom_range(0, 2) != 0);
    endtask

    initial begin
        int k;
        aresetn = 0; port_en = '0; acvalids = 0; acaddrs = '0; acsnoops = '0;
        acprots = '0; acreadym = '0; crvalidm = '0; crrespm = '0; crreadys = 0;
        model_reset();
        @(negedge aclk);
        @(negedge aclk);
        check_outputs();
        aresetn = 1;
        @(negedge aclk);

        // All ports ready at once: minimum latency and merged 5'h09.
        port_en = 4'hF; acreadym = 4'hF; crvalidm = 4'hF;
        crrespm = {5'h00, 5'h01, 5'h08, 5'h00};
        acaddrs = 44'h123_4567_89AB; acsnoops = 4'h7; acprots = 3'h5;
        crreadys = 0; acvalids = 1;
        cycle();
        tb_check("lat_acvalidm_t1", 64'(acvalidm), 64'hF);
        cycle();
        tb_check("lat_crvalids_t2", 64'(crvalids), 64'd0);
        cycle();
        tb_check("lat_crvalids_t3", 64'(crvalids), 64'd1);
        tb_check("lat_crresps_09", 64'(crresps), 64'h09);
        for (k = 0; k < 10; k++) cycle();
        tb_check("stall_crresps", 64'(crresps), 64'h09);
        crreadys = 1; acvalids = 0;
        cycle();
        tb_check("acreadys_after_resp", 64'(acreadys), 64'd1);

        // No ports enabled: immediate zero response.
        port_en = '0; acvalids = 1;
        cycle();
        acvalids = 0; crreadys = 0;
        tb_check("pe0_crvalids", 64'(crvalids), 64'd1);
        tb_check("pe0_crresps", 64'(crresps), 64'd0);
        tb_check("pe0_acvalidm", 64'(acvalidm), 64'd0);
        crreadys = 1;
        cycle();

        // Ports 0 and 2; both stall AC while their CR is already valid.
        port_en = 4'b0101; acreadym = 4'b1010; crvalidm = 4'hF;
        crrespm = {5'h1F, 5'h10, 5'h1F, 5'h02};
        acvalids = 1; crreadys = 0;
        cycle();
        acvalids = 0;
        for (k = 0; k < 5; k++) cycle();
        tb_check("p2_acvalid_held", 64'(acvalidm[2]), 64'd1);
        tb_check("p0_crready_blocked", 64'(crreadym[0]), 64'd0);
        acreadym = 4'hF;
        k = 0;
        while (!m_resp && k < 20) begin cycle(); k++; end
        tb_check("early_cr_bound", 64'(m_resp), 64'd1);
        cycle();
        tb_check("early_cr_merge", 64'(crresps), 64'h12);
        crreadys = 1;
        cycle();

        // Reset in the middle of a snoop with two ports pending.
        port_en = 4'b0011; acreadym = '0; crvalidm = '0; acvalids = 1;
        cycle();
        acvalids = 0;
        cycle();
        aresetn = 0;
        #1;
        tb_check("rst_acvalidm", 64'(acvalidm), 64'd0);
        tb_check("rst_crreadym", 64'(crreadym), 64'd0);
        tb_check("rst_crvalids", 64'(crvalids), 64'd0);
        tb_check("rst_acreadys", 64'(acreadys), 64'd1);
        model_reset();
        @(negedge aclk);
        aresetn = 1;
        port_en = 4'b0110; acreadym = 4'hF; crvalidm = 4'hF;
        crrespm = {5'h00, 5'h04, 5'h01, 5'h00}; acvalids = 1; crreadys = 1;
        cycle();
        acvalids = 0;
        k = 0;
        while ((m_busy || m_resp) && k < 20) begin cycle(); k++; end
        tb_check("post_rst_done", 64'(m_busy || m_resp), 64'd0);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            rand_inputs();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ace_snoop_bcast_ctrl.md
Name: ace_snoop_bcast_ctrl

Overview:
Snoop broadcast controller for the ACE snoop channels (AC address, CR response). It accepts one upstream snoop, broadcasts it to up to NUM_PORTS snooped masters, and collects each port's CR response. It then returns one OR-merged CR response upstream. It sits between the interconnect snoop source and the per-port ACE CR register slices; one snoop is outstanding at a time.

Parameters:
NUM_PORTS, 4, number of snooped downstream ports (1..16)
ADDR_W, 44, snoop address width

Ports:
aclk  input  1  clock
aresetn  input  1  asynchronous active-low reset
port_en  input  NUM_PORTS  ports to snoop; sampled at AC accept
acvalids  input  1  upstream snoop valid
acreadys  output  1  upstream snoop ready
acaddrs  input  ADDR_W  upstream snoop address
acsnoops  input  4  upstream snoop type
acprots  input  3  upstream snoop prot
acvalidm  output  NUM_PORTS  per-port snoop valid
acreadym  input  NUM_PORTS  per-port snoop ready
acaddrm  output  ADDR_W  broadcast address (shared by all ports)
acsnoopm  output  4  broadcast snoop type
acprotm  output  3  broadcast prot
crvalidm  input  NUM_PORTS  per-port response valid
crreadym  output  NUM_PORTS  per-port response ready
crrespm  input  5*NUM_PORTS  per-port response; port i uses bits [5i+4:5i]
crvalids  output  1  merged response valid
crreadys  input  1  merged response ready
crresps  output  5  merged response

Behaviour:
- Registers: state, ac_pend[NUM_PORTS], cr_pend[NUM_PORTS], resp_acc[4:0], and the AC payload register.
- Reset (async, aresetn low) clears all registers and state returns to IDLE. Outputs at reset: acreadys=1 (IDLE); acvalidm=0; crreadym=0; crvalids=0; crresps=0; acaddrm/acsnoopm/acprotm=0.
- IDLE:
  - acreadys=1.
  - On acvalids&acreadys: capture the payload, ac_pend=cr_pend=port_en, resp_acc=0.
  - If port_en!=0, go to SNOOP; else go to RESP (merged response 0).
- SNOOP:
  - acreadys=0.
  - acvalidm=ac_pend. A port's valid deasserts only after its own handshake; there is no withdrawal.
  - Per port i, acvalidm[i]&acreadym[i] clears ac_pend[i] on the next edge.
  - crreadym=cr_pend&~ac_pend. A CR handshake is accepted only from ports whose AC has completed.
  - Per port, crvalidm[i]&crreadym[i] clears cr_pend[i] and ORs crrespm slice i into resp_acc.
  - Multiple ports may hand-shake AC and/or CR in the same cycle; all of them are applied.
  - When the next cr_pend is all zero, go to RESP. The final resp_acc includes same-cycle responses.
- RESP:
  - crvalids=1, crresps=resp_acc. Payload is held stable until crreadys.
  - On crreadys go to IDLE. acreadys rises the cycle after.
- Merge rule: bitwise OR of all collected responses (DataTransfer, Error, PassDirty, IsShared, WasUnique).
- Disabled ports (port_en[i]=0) never see acvalidm and their CR is never accepted (crreadym[i]=0).
- CR asserted by a port before its AC handshake is stalled; it is not dropped.
- Minimum latency:
  - AC accept at edge T; acvalidm high in T+1.
  - If all ports accept AC in T+1, CR is accepted from T+2.
  - With CR valid in T+2, crvalids is high in T+3.
- Throughput: one snoop per (ports' latency + 3) cycles minimum; no pipelining of snoops.
- Reset mid-operation aborts the snoop: valids drop immediately (async), and no response is issued.
- All outputs are driven from registers or state decode; there is no combinational path from any *ready input to any *valid output.

Test Plan:
- NUM_PORTS=4, port_en=4'hF, all acreadym/crvalidm=1, crrespm slices 5'h00,5'h08,5'h01,5'h00 -> acvalidm=4'hF for 1 cycle; crvalids asserted 3 cycles after AC accept with crresps=5'h09; acreadys low until 1 cycle after crreadys.
- port_en=4'b0101, port 2 holds acreadym=0 for 5 cycles -> acvalidm[2] stays high 6 cycles; acvalidm[1],[3] never assert; crreadym[2] stays 0 until its AC handshake; crvalids only after port 2's CR.
- port_en=0, snoop accepted -> no acvalidm; crvalids=1, crresps=0 one cycle later.
- Port 0 drives crvalidm=1 with 5'h02 before its AC handshake -> crreadym[0]=0 until after AC completes; response then merged, crresps bit1 set.
- crreadys held 0 for 10 cycles in RESP -> crvalids and crresps stable throughout; acreadys=0; a new acvalids is not accepted.
- Assert aresetn=0 mid-SNOOP with 2 ports pending -> acvalidm, crreadym, crvalids=0 immediately; after release, state is IDLE, acreadys=1, and the next snoop completes normally.
